// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, packet-locked sharing of one uart_tx between two
//            byte-stream requesters (A and B).
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int MAX_BURST    = 16,
   parameter int HOLD_TIMEOUT = 64
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_a_valid,
   input  logic [7:0] i_a_data,
   input  logic       i_a_last,
   output logic       o_a_ready,
   input  logic       i_b_valid,
   input  logic [7:0] i_b_data,
   input  logic       i_b_last,
   output logic       o_b_ready,
   output logic       o_tx_start,
   output logic [7:0] o_tx_byte,
   input  logic       i_tx_done,
   output logic [1:0] o_grant,
   output logic       o_busy
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_send = 2'd1;
   localparam logic [1:0] c_wait = 2'd2;
   localparam logic [1:0] c_next = 2'd3;

   localparam logic [7:0]  c_max_burst = 8'(MAX_BURST);
   localparam logic [15:0] c_hold_last = 16'(HOLD_TIMEOUT - 1);

   logic [1:0]  r_state;
   logic        r_pref_b;
   logic [1:0]  r_grant;
   logic        r_last;
   logic [7:0]  r_burst_cnt;
   logic [15:0] r_to_cnt;
   logic [7:0]  r_tx_byte;

   logic       w_idle;
   logic       w_next;
   logic       w_pick_b;
   logic       w_owner_valid;
   logic [7:0] w_owner_data;
   logic       w_owner_last;

   assign w_idle   = (r_state == c_idle);
   assign w_next   = (r_state == c_next);
   // B wins in IDLE when it is alone, or when both are valid and B is preferred.
   assign w_pick_b = i_b_valid & (~i_a_valid | r_pref_b);

   assign w_owner_valid = (r_grant[0] & i_a_valid) | (r_grant[1] & i_b_valid);
   assign w_owner_data  = r_grant[1] ? i_b_data : i_a_data;
   assign w_owner_last  = r_grant[1] ? i_b_last : i_a_last;

   assign o_a_ready  = (w_idle & i_a_valid & ~w_pick_b) | (w_next & r_grant[0]);
   assign o_b_ready  = (w_idle & w_pick_b) | (w_next & r_grant[1]);
   assign o_tx_start = (r_state == c_send);
   assign o_tx_byte  = r_tx_byte;
   assign o_grant    = r_grant;
   assign o_busy     = ~w_idle;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= c_idle;
         r_pref_b    <= 1'b0;
         r_grant     <= 2'b00;
         r_last      <= 1'b0;
         r_burst_cnt <= 8'd0;
         r_to_cnt    <= 16'd0;
         r_tx_byte   <= 8'h00;
      end else begin
         case (r_state)
            c_idle: begin
               if (i_a_valid | i_b_valid) begin
                  r_tx_byte   <= w_pick_b ? i_b_data : i_a_data;
                  r_last      <= w_pick_b ? i_b_last : i_a_last;
                  r_grant     <= w_pick_b ? 2'b10 : 2'b01;
                  r_burst_cnt <= 8'd1;
                  r_state     <= c_send;
               end
            end
            c_send: begin
               r_state <= c_wait;
            end
            c_wait: begin
               if (i_tx_done) begin
                  if (r_last || (r_burst_cnt == c_max_burst)) begin
                     r_grant  <= 2'b00;
                     r_pref_b <= r_grant[0];
                     r_state  <= c_idle;
                  end else begin
                     r_to_cnt <= 16'd0;
                     r_state  <= c_next;
                  end
               end
            end
            c_next: begin
               if (w_owner_valid) begin
                  r_tx_byte   <= w_owner_data;
                  r_last      <= w_owner_last;
                  r_burst_cnt <= r_burst_cnt + 8'd1;
                  r_state     <= c_send;
               end else if (r_to_cnt == c_hold_last) begin
                  // Owner stalled too long: hand the transmitter to the other side.
                  r_grant  <= 2'b00;
                  r_pref_b <= r_grant[0];
                  r_state  <= c_idle;
               end else begin
                  r_to_cnt <= r_to_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
